// File: rtl/mod4_counter.sv
// mod4_counter: synchronous modulo-N up/down counter (default 2-bit, mod 4).
// Replaces a ripple counter. Every bit of op changes on the same rising edge,
// so there is no ripple skew between bits and op never glitches between edges.
// Per-edge priority: reset, load, count, hold.
// Note: rst_n is an ACTIVE-HIGH synchronous reset despite its name.
module mod4_counter #(
  parameter int WIDTH   = 2,
  parameter int MODULUS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] op,
  output logic             tc
);

  // Reject configurations that cannot describe a legal modulo counter.
  generate
    if (WIDTH < 1 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
      $error("mod4_counter: MODULUS must be in 2..2^WIDTH");
    end
  endgenerate

  // MODULUS may equal 2^WIDTH, so it needs one extra bit to be represented.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO    = '0;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH:0]   load_ext;
  logic [WIDTH:0]   load_mod;

  // Out-of-range load values are folded back into 0..MODULUS-1. When MODULUS
  // is 2^WIDTH this reduces to a plain copy.
  always_comb begin
    load_ext = {1'b0, load_val};
    load_mod = load_ext % MOD_EXT;
  end

  // Next-state selection in priority order: reset, load, count, hold.
  always_comb begin
    count_d = count_q;
    if (rst_n) begin
      count_d = ZERO;
    end else if (load) begin
      count_d = load_mod[WIDTH-1:0];
    end else if (en) begin
      if (up_dn) begin
        count_d = (count_q == MAX_VAL) ? ZERO : count_q + ONE;
      end else begin
        count_d = (count_q == ZERO) ? MAX_VAL : count_q - ONE;
      end
    end
  end

  // Count register. All bits update together on the single clock edge.
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  // Terminal count depends on the current direction. It does not look at en,
  // so a sequencer can see "about to wrap" even while the counter is held.
  always_comb begin
    op = count_q;
    tc = up_dn ? (count_q == MAX_VAL) : (count_q == ZERO);
  end

endmodule

// File: tb/tb_mod4_counter.sv
// Directed testbench for mod4_counter in its default 2-bit / mod-4 setup.
module tb_mod4_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [1:0] load_val;
  logic [1:0] op;
  logic       tc;

  int checks_total;
  int checks_passed;

  mod4_counter #(.WIDTH(2), .MODULUS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .op       (op),
    .tc       (tc)
  );

  // Clock and reset block: 10 ns clock; reset is driven by the sequence below.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one rising edge, then return to the falling edge for sampling
  // and for driving the next set of inputs.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One comparison point.
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks_total++;
    assert (obs === exp) begin
      checks_passed++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [1:0] exp_op, input logic exp_tc);
    check({tag, " op"}, {6'd0, op}, {6'd0, exp_op});
    check({tag, " tc"}, {7'd0, tc}, {7'd0, exp_tc});
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst_n    = 1'b1;
    en       = 1'b1;
    up_dn    = 1'b1;
    load     = 1'b0;
    load_val = 2'd0;

    // Reset held for two edges with en=1.
    step();
    check_state("reset edge1", 2'd0, 1'b0);
    step();
    check_state("reset edge2", 2'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_state("reset released", 2'd0, 1'b0);

    // Up wrap: 1,2,3,0,1 with tc only at 3.
    step(); check_state("up 1", 2'd1, 1'b0);
    step(); check_state("up 2", 2'd2, 1'b0);
    step(); check_state("up 3", 2'd3, 1'b1);
    step(); check_state("up wrap 0", 2'd0, 1'b0);
    step(); check_state("up 1 again", 2'd1, 1'b0);

    // Back to 0, then down wrap: 3,2,1,0,3 with tc only at 0.
    rst_n = 1'b1;
    step(); check_state("reset before down", 2'd0, 1'b0);
    rst_n = 1'b0;
    up_dn = 1'b0;
    #1;
    check_state("tc follows up_dn at 0", 2'd0, 1'b1);
    step(); check_state("down wrap 3", 2'd3, 1'b0);
    step(); check_state("down 2", 2'd2, 1'b0);
    step(); check_state("down 1", 2'd1, 1'b0);
    step(); check_state("down 0", 2'd0, 1'b1);
    step(); check_state("down wrap 3 again", 2'd3, 1'b0);

    // Reach 2, then hold for three edges.
    step(); check_state("down to 2", 2'd2, 1'b0);
    en = 1'b0;
    step(); check_state("hold 1", 2'd2, 1'b0);
    step(); check_state("hold 2", 2'd2, 1'b0);
    step(); check_state("hold 3", 2'd2, 1'b0);

    // Load overrides counting on the same edge.
    load = 1'b1; load_val = 2'd1; en = 1'b1;
    step(); check_state("load 1 over count", 2'd1, 1'b0);

    // tc is independent of en: load 3, then hold with up_dn=1.
    load_val = 2'd3; up_dn = 1'b1; en = 1'b0;
    step(); check_state("load 3", 2'd3, 1'b1);
    load = 1'b0;
    step(); check_state("hold at 3 tc", 2'd3, 1'b1);

    // Priority: reset beats load and en.
    rst_n = 1'b1; load = 1'b1; load_val = 2'd3; en = 1'b1;
    step(); check_state("reset over load", 2'd0, 1'b0);
    // Without reset, load beats count.
    rst_n = 1'b0; load_val = 2'd2;
    step(); check_state("load over count", 2'd2, 1'b0);

    // Reset mid-run while counting up.
    load = 1'b1; load_val = 2'd0;
    step(); check_state("load 0", 2'd0, 1'b0);
    load = 1'b0;
    step(); check_state("run 1", 2'd1, 1'b0);
    step(); check_state("run 2", 2'd2, 1'b0);
    rst_n = 1'b1;
    step(); check_state("mid-run reset", 2'd0, 1'b0);
    rst_n = 1'b0;
    step(); check_state("resume 1", 2'd1, 1'b0);

    // Direction change takes effect on the very next edge.
    up_dn = 1'b0;
    step(); check_state("direction flip", 2'd0, 1'b1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/mod4_counter.md
Name: mod4_counter

Overview:
- Synchronous modulo-N up/down counter; default configuration is a 2-bit mod-4 counter.
- Functionally replaces a ripple (asynchronous) mod-4 counter: same count sequence, but every bit changes on the single clock edge with no ripple skew.
- Used as a small cycle/phase sequencer.
- Provides enable, direction, parallel load and a terminal-count flag.

Parameters:
- WIDTH, 2, counter width in bits.
- MODULUS, 4, count modulus; legal range 2..2^WIDTH. Values outside this range are rejected at elaboration.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous reset, ACTIVE-HIGH. Despite the name, 1 = reset asserted. Sampled on rising clk.
- en  input  1  count enable; 1 = advance one step per clock.
- up_dn  input  1  direction; 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load request.
- load_val  input  WIDTH  value to load.
- op  output  WIDTH  current count (registered).
- tc  output  1  terminal count flag (combinational from op and up_dn).

Behaviour:
- All state updates occur on the rising clk edge. There are no asynchronous paths.
- Priority per edge, highest first: reset, load, count, hold.
- Reset:
  - rst_n=1 at the edge sets op to 0. tc then follows its normal rule.
  - Reset overrides load and en on the same edge.
  - Reset mid-count forces op to 0 on the next edge regardless of state. Counting resumes on the first edge after rst_n returns to 0.
- Load (load=1, no reset):
  - op takes load_val when load_val < MODULUS.
  - Otherwise op takes load_val mod MODULUS. For the default MODULUS=4 with WIDTH=2, every load_val is legal.
  - Load overrides en and up_dn.
- Count (en=1, load=0, no reset):
  - up_dn=1: op = (op == MODULUS-1) ? 0 : op+1.
  - up_dn=0: op = (op == 0) ? MODULUS-1 : op-1.
  - Default up sequence: 0,1,2,3,0,... Default down sequence: 3,2,1,0,3,...
- Hold (en=0, load=0, no reset): op unchanged.
- Latency: one clock from any input to op. op never glitches between edges.
- tc:
  - tc = 1 when (up_dn=1 and op = MODULUS-1) or (up_dn=0 and op = 0); otherwise 0.
  - tc is independent of en.
- Direction change takes effect on the same edge it is sampled; there is no pipeline.
- Values of op at or above MODULUS are unreachable when MODULUS < 2^WIDTH.
- op is undefined before the first reset edge. Benches must apply reset first.

Test Plan:
- Reset: hold rst_n=1 for 2 edges with en=1 -> op=0 after the first edge, stays 0. Release with up_dn=1 -> tc=0.
- Up wrap: en=1, up_dn=1 from op=0 for 5 edges -> op 1,2,3,0,1. tc=1 only while op=3.
- Down wrap: en=1, up_dn=0 from op=0 for 5 edges -> op 3,2,1,0,3. tc=1 only while op=0.
- Hold and load: en=0 at op=2 for 3 edges -> stays 2. Then load=1, load_val=1 with en=1 -> op=1 next edge, no count on that edge.
- Priority: rst_n=1, load=1, load_val=3, en=1 on the same edge -> op=0. With rst_n=0, load=1, en=1 -> op=load_val.
- Reset mid-run: counting up, assert rst_n=1 when op=2 -> op=0 at the next edge. Deassert -> op=1 at the following edge.
